ctrl_seq: RTL

Sequenced control unit for the processor core: decodes the top bits of each instruction into datapath controls, as the combinational decoder does. Adds registered compare flags that persist from a CMP to any later branch, and a run/halt FSM with a start/done handshake to the bench. Also adds a parametrised load-stall counter for multi-cycle data memory. Sits between instruction ROM / ALU flags and the program counter, register file and data memory.

---
 rtl/ctrl_seq_pkg.sv | 49 ++++
 rtl/ctrl_seq_if.sv | 38 +++
 rtl/ctrl_seq_decode.sv | 54 +++++
 rtl/ctrl_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
// Shared definitions for the sequenced control unit: FSM state encoding,
// R-type function codes, write-back select codes and the decoded
// instruction record passed from ctrl_decode to ctrl_seq.
// No ports (package).
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    STALL,
    HALT
  } ctrl_state_t;

  // R-type function field values (bits [INSTR_W-3:INSTR_W-6])
  localparam logic [3:0] F_SHL = 4'b0010;
  localparam logic [3:0] F_SHR = 4'b0011;
  localparam logic [3:0] F_SHX = 4'b1111;
  localparam logic [3:0] F_BEQ = 4'b1000;
  localparam logic [3:0] F_BNE = 4'b1001;
  localparam logic [3:0] F_BLT = 4'b1010;
  localparam logic [3:0] F_BR  = 4'b1011;
  localparam logic [3:0] F_STR = 4'b1100;
  localparam logic [3:0] F_LDR = 4'b1101;

  // Write-back select values driven on alu_mem_imm
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_MOV = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Stall counter width; LOAD_LAT is limited to 0..15
  localparam int STALL_W = 4;

  typedef struct packed {
    logic       halt;
    logic       cmp;
    logic       load;
    logic       branch;
    logic [3:0] func;
    logic       dest_reg;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_mem_imm;
  } decode_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if
// Bundles the bench/datapath-facing signals of ctrl_seq.
//   master: drives start, instruction, zero, less_than; observes controls
//   slave : the control unit side (receives instruction/flags, drives controls)
// Parameters: INSTR_W instruction width, CNT_W cycle counter width.
interface ctrl_seq_if #(
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);

  logic               start;
  logic [INSTR_W-1:0] instruction;
  logic               zero;
  logic               less_than;
  logic               pc_init;
  logic               pc_en;
  logic               branch_en;
  logic               dest_reg;
  logic               alu_src;
  logic               reg_write_en;
  logic               mem_write_en;
  logic [1:0]         alu_mem_imm;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output start, instruction, zero, less_than,
    input  pc_init, pc_en, branch_en, dest_reg, alu_src, reg_write_en,
           mem_write_en, alu_mem_imm, done, cycle_count
  );

  modport slave (
    input  start, instruction, zero, less_than,
    output pc_init, pc_en, branch_en, dest_reg, alu_src, reg_write_en,
           mem_write_en, alu_mem_imm, done, cycle_count
  );

endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_decode
// Pure combinational instruction decode. Classifies the instruction by its
// top six bits and produces the raw datapath controls, before any gating by
// the sequencer state.
// Ports:
//   instruction in  INSTR_W  current machine code
//   dec         out decode_t decoded class flags, function field and controls
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W = 9
) (
  input  logic [INSTR_W-1:0] instruction,
  output decode_t            dec
);

  logic [1:0] top2;
  logic [3:0] func;
  logic       i_type;
  logic       m_type;
  logic       r_type;
  logic       is_mov;
  logic       is_cmp;
  logic       is_shift;
  logic       is_branch;
  logic       is_store;
  logic       is_load;

  assign top2   = instruction[INSTR_W-1 -: 2];
  assign func   = instruction[INSTR_W-3 -: 4];
  assign i_type = top2[1];
  assign m_type = (top2 == 2'b01);
  assign r_type = (top2 == 2'b00);

  // For M-type the bit right below the class bits picks MOV over CMP
  assign is_cmp    = m_type & ~func[3];
  assign is_mov    = m_type &  func[3];
  assign is_shift  = r_type & ((func == F_SHL) | (func == F_SHR) | (func == F_SHX));
  assign is_branch = r_type & (func[3:2] == 2'b10);
  assign is_store  = r_type & (func == F_STR);
  assign is_load   = r_type & (func == F_LDR);

  assign dec.halt        = (instruction == '0);
  assign dec.cmp         = is_cmp;
  assign dec.load        = is_load;
  assign dec.branch      = is_branch;
  assign dec.func        = func;
  assign dec.dest_reg    = m_type;
  assign dec.alu_src     = is_shift;
  assign dec.reg_write   = ~(is_cmp | is_branch | is_store);
  assign dec.mem_write   = is_store;
  assign dec.alu_mem_imm = {is_mov | i_type, is_load | i_type};

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq
// Sequenced control unit: run/halt FSM with a start/done handshake,
// registered compare flags consumed by branches, a load-stall counter for
// multi-cycle data memory and an optional executed-cycle counter.
// Optional feature macro: CTRL_CYCLE_COUNT_EN (cycle_count live when defined,
// tied to zero otherwise).
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of ctrl_seq_if (start, instruction, zero, less_than
//          in; pc_init, pc_en, branch_en, dest_reg, alu_src, reg_write_en,
//          mem_write_en, alu_mem_imm, done, cycle_count out)
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W  = 9,
  parameter int LOAD_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  ctrl_seq_if.slave   bus
);

  localparam bit STALL_EN = (LOAD_LAT > 0);

  ctrl_state_t        state;
  ctrl_state_t        state_n;
  logic [STALL_W-1:0] stall_cnt;
  logic               zero_q;
  logic               lt_q;
  logic               done_q;
  decode_t            dec;
  logic               take;
  logic               last_stall;

  logic       pc_init;
  logic       pc_en;
  logic       branch_en;
  logic       dest_reg;
  logic       alu_src;
  logic       reg_write_en;
  logic       mem_write_en;
  logic [1:0] alu_mem_imm;

  ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instruction (bus.instruction),
    .dec         (dec)
  );

  // Branch condition evaluated against the registered flags, so a branch
  // right after a CMP sees the values captured on that CMP's edge.
  always_comb begin
    take = 1'b0;
    case (dec.func)
      F_BEQ:   take = zero_q;
      F_BNE:   take = ~zero_q;
      F_BLT:   take = lt_q;
      F_BR:    take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  assign last_stall = (stall_cnt == STALL_W'(1));

  // Next-state and per-state output gating of the raw decode.
  always_comb begin
    state_n      = state;
    pc_init      = 1'b0;
    pc_en        = 1'b0;
    branch_en    = 1'b0;
    dest_reg     = 1'b0;
    alu_src      = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    alu_mem_imm  = SEL_ALU;
    case (state)
      IDLE: begin
        pc_init = 1'b1;
        if (bus.start) state_n = ARM;
      end
      ARM: begin
        pc_init = 1'b1;
        if (!bus.start) state_n = RUN;
      end
      RUN: begin
        dest_reg     = dec.dest_reg;
        alu_src      = dec.alu_src;
        reg_write_en = dec.reg_write;
        mem_write_en = dec.mem_write;
        alu_mem_imm  = dec.alu_mem_imm;
        branch_en    = dec.branch & take;
        pc_en        = 1'b1;
        if (dec.halt) begin
          state_n = HALT;
          pc_en   = 1'b0;
        end else if (dec.load && STALL_EN) begin
          state_n      = STALL;
          pc_en        = 1'b0;
          reg_write_en = 1'b0;
        end
      end
      STALL: begin
        // The load is still on the instruction bus because pc_en held it.
        dest_reg     = dec.dest_reg;
        alu_src      = dec.alu_src;
        alu_mem_imm  = dec.alu_mem_imm;
        reg_write_en = dec.reg_write & last_stall;
        pc_en        = last_stall;
        if (last_stall) state_n = RUN;
      end
      HALT: begin
        if (bus.start) state_n = ARM;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, stall counter, compare flags and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state_n == HALT);
      if (state == RUN && state_n == STALL) begin
        stall_cnt <= STALL_W'(LOAD_LAT);
      end else if (state == STALL) begin
        stall_cnt <= stall_cnt - STALL_W'(1);
      end
      if (state == RUN && dec.cmp) begin
        zero_q <= bus.zero;
        lt_q   <= bus.less_than;
      end
    end
  end

`ifdef CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_q;

  // Counts RUN/STALL cycles, restarting at each launch and saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (state == ARM && state_n == RUN) begin
      cycle_q <= '0;
    end else if ((state == RUN || state == STALL) && (cycle_q != {CNT_W{1'b1}})) begin
      cycle_q <= cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.cycle_count = cycle_q;
`else
  assign bus.cycle_count = {CNT_W{1'b0}};
`endif

  assign bus.pc_init      = pc_init;
  assign bus.pc_en        = pc_en;
  assign bus.branch_en    = branch_en;
  assign bus.dest_reg     = dest_reg;
  assign bus.alu_src      = alu_src;
  assign bus.reg_write_en = reg_write_en;
  assign bus.mem_write_en = mem_write_en;
  assign bus.alu_mem_imm  = alu_mem_imm;
  assign bus.done         = done_q;

endmodule
